// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage:
// ALU operation codes, forwarding selects and mul/div FSM states.
package ex_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SLL   = 5'd8;
  localparam logic [4:0] ALU_SRL   = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_LUI   = 5'd11;
  localparam logic [4:0] ALU_MULT  = 5'd12;
  localparam logic [4:0] ALU_MULTU = 5'd13;
  localparam logic [4:0] ALU_DIV   = 5'd14;
  localparam logic [4:0] ALU_DIVU  = 5'd15;
  localparam logic [4:0] ALU_MFHI  = 5'd16;
  localparam logic [4:0] ALU_MFLO  = 5'd17;
  localparam logic [4:0] ALU_MTHI  = 5'd18;
  localparam logic [4:0] ALU_MTLO  = 5'd19;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_WB    = 2'd2;
  localparam logic [1:0] FWD_RSV   = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= ALU_MULT) && (op <= ALU_DIVU);
  endfunction

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative 32-step multiply / restoring divide with HI/LO registers.
// Operands are taken as magnitudes; signs are applied on the last step.
module muldiv_unit
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_stall
);

  md_state_e   r_state;
  logic [4:0]  r_cnt;
  logic        r_div;
  logic        r_sgn_q;
  logic        r_sgn_r;
  logic        r_dz;
  logic [31:0] r_acc;
  logic [31:0] r_q;
  logic [31:0] r_b;
  logic [31:0] r_dvd;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_start;
  logic        w_signed;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_ma;
  logic [31:0] w_mb;
  logic [32:0] w_sum;
  logic [32:0] w_rsh;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_acc_nx;
  logic [31:0] w_q_nx;
  logic [63:0] w_prod;

  assign w_start  = (r_state == MD_IDLE) && is_muldiv(i_op);
  assign o_stall  = w_start || (r_state == MD_RUN);
  assign o_hi     = r_hi;
  assign o_lo     = r_lo;

  assign w_signed = (i_op == ALU_MULT) || (i_op == ALU_DIV);
  assign w_sa     = w_signed & i_a[31];
  assign w_sb     = w_signed & i_b[31];
  assign w_ma     = w_sa ? -i_a : i_a;
  assign w_mb     = w_sb ? -i_b : i_b;

  // Multiply: {acc,q} shifts right, multiplier consumed from q[0].
  assign w_sum  = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_b : 32'd0)};
  // Divide: {acc,q} shifts left, quotient bits enter at q[0].
  assign w_rsh  = {r_acc, r_q[31]};
  assign w_diff = w_rsh - {1'b0, r_b};
  assign w_ge   = ~w_diff[32];

  always_comb begin
    if (r_div) begin
      w_acc_nx = w_ge ? w_diff[31:0] : w_rsh[31:0];
      w_q_nx   = {r_q[30:0], w_ge};
    end else begin
      w_acc_nx = w_sum[32:1];
      w_q_nx   = {w_sum[0], r_q[31:1]};
    end
  end

  assign w_prod = {w_acc_nx, w_q_nx};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_sgn_q <= 1'b0;
      r_sgn_r <= 1'b0;
      r_dz    <= 1'b0;
      r_acc   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_dvd   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      unique case (r_state)
        MD_IDLE: begin
          if (w_start) begin
            r_state <= MD_RUN;
            r_cnt   <= '0;
            r_div   <= (i_op == ALU_DIV) || (i_op == ALU_DIVU);
            r_sgn_q <= w_sa ^ w_sb;
            r_sgn_r <= w_sa;
            r_dz    <= (i_b == 32'd0);
            r_acc   <= '0;
            r_q     <= w_ma;
            r_b     <= w_mb;
            r_dvd   <= i_a;
          end else if (i_op == ALU_MTHI) begin
            r_hi <= i_a;
          end else if (i_op == ALU_MTLO) begin
            r_lo <= i_a;
          end
        end
        MD_RUN: begin
          r_acc <= w_acc_nx;
          r_q   <= w_q_nx;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= MD_DONE;
            if (!r_div) begin
              {r_hi, r_lo} <= r_sgn_q ? -w_prod : w_prod;
            end else if (r_dz) begin
              r_hi <= r_dvd;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_lo <= r_sgn_q ? -w_q_nx : w_q_nx;
              r_hi <= r_sgn_r ? -w_acc_nx : w_acc_nx;
            end
          end
        end
        MD_DONE: r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch target, write-back
// register select, and the multi-cycle multiply/divide unit.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegDst_in,
  input  logic [4:0]  ALUOp_in,
  input  logic        ALUSrc_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] Reg1_in,
  input  logic [31:0] Reg2_in,
  input  logic [31:0] Ext_in,
  input  logic [4:0]  Rt_in,
  input  logic [4:0]  Rd_in,
  input  logic [1:0]  FwdA,
  input  logic [1:0]  FwdB,
  input  logic [31:0] EXMEM_Result,
  input  logic [31:0] WB_Data,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic [31:0] BranchTarget,
  output logic [31:0] StoreData,
  output logic [4:0]  WriteReg,
  output logic        Stall
);

  logic [31:0] w_a;
  logic [31:0] w_fb;
  logic [31:0] w_b;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic [31:0] w_res;
  logic [4:0]  w_sh;

  function automatic logic [31:0] fwd_mux(
    input logic [1:0]  sel,
    input logic [31:0] reg_v,
    input logic [31:0] exm_v,
    input logic [31:0] wb_v
  );
    logic [31:0] v;
    v = reg_v;
    unique case (1'b1)
      (sel == FWD_EXMEM): v = exm_v;
      (sel == FWD_WB):    v = wb_v;
      default:            v = reg_v;
    endcase
    return v;
  endfunction

  assign w_a  = fwd_mux(FwdA, Reg1_in, EXMEM_Result, WB_Data);
  assign w_fb = fwd_mux(FwdB, Reg2_in, EXMEM_Result, WB_Data);
  assign w_b  = ALUSrc_in ? Ext_in : w_fb;
  assign w_sh = Ext_in[10:6];

  always_comb begin
    w_res = '0;
    case (ALUOp_in)
      ALU_ADD:  w_res = w_a + w_b;
      ALU_SUB:  w_res = w_a - w_b;
      ALU_AND:  w_res = w_a & w_b;
      ALU_OR:   w_res = w_a | w_b;
      ALU_XOR:  w_res = w_a ^ w_b;
      ALU_NOR:  w_res = ~(w_a | w_b);
      ALU_SLT:  w_res = {31'd0, $signed(w_a) < $signed(w_b)};
      ALU_SLTU: w_res = {31'd0, w_a < w_b};
      ALU_SLL:  w_res = w_fb << w_sh;
      ALU_SRL:  w_res = w_fb >> w_sh;
      ALU_SRA:  w_res = $unsigned($signed(w_fb) >>> w_sh);
      ALU_LUI:  w_res = {w_b[15:0], 16'd0};
      ALU_MFHI: w_res = w_hi;
      ALU_MFLO: w_res = w_lo;
      default:  w_res = '0;
    endcase
  end

  assign ALUResult    = w_res;
  assign Zero         = (w_res == 32'd0);
  assign BranchTarget = PC_in + {Ext_in[29:0], 2'b00};
  assign StoreData    = w_fb;
  assign WriteReg     = RegDst_in ? Rd_in : Rt_in;

  muldiv_unit u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .i_op    (ALUOp_in),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_stall (Stall)
  );

endmodule
